// File: rtl/rv32i_types.sv
// Shared types for the cache-to-memory arbiter: FSM states, grant owner and line geometry.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam int LINE_OFFSET_W = 5;

endpackage

// File: rtl/arb_pick.sv
// Combinational two-way grant decision between the I-cache and D-cache miss requests.
module arb_pick
    import rv32i_types::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic       i_req,
    input  logic       d_req,
    input  arb_owner_t last_grant,
    input  logic       starve_hit,
    output arb_owner_t winner
);

    always_comb begin
        winner = OWN_I;
        if (d_req && !i_req) begin
            winner = OWN_D;
        end else if (i_req && d_req) begin
            // Fixed priority favours D unless I has lost too many times in a row.
            if (FIXED_PRIO != 0) begin
                winner = starve_hit ? OWN_I : OWN_D;
            end else begin
                winner = (last_grant == OWN_I) ? OWN_D : OWN_I;
            end
        end
    end

endmodule

// File: rtl/cacheline_arbiter.sv
// Shares one pmem burst port between the I-cache and D-cache miss paths, one line transaction at a time.
module cacheline_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_W       = 256,
    parameter int ADDR_W       = 32,
    parameter int FIXED_PRIO   = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              arb_busy
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << LINE_OFFSET_W) - 1);

    arb_state_t        state_q, state_d;
    arb_owner_t        last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;

    logic       i_req, d_req, starve_hit, busy;
    arb_owner_t winner;

    assign i_req      = i_read;
    assign d_req      = d_read | d_write;
    assign starve_hit = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    arb_pick #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_pick (
        .i_req     (i_req),
        .d_req     (d_req),
        .last_grant(last_grant_q),
        .starve_hit(starve_hit),
        .winner    (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= OWN_I;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    last_grant_d = winner;
                    if (winner == OWN_I) begin
                        state_d      = I_BUSY;
                        addr_d       = i_addr & LINE_MASK;
                        wdata_d      = '0;
                        write_d      = 1'b0;
                        starve_cnt_d = '0;
                    end else begin
                        // A simultaneous read+write from D is resolved as a write.
                        state_d = D_BUSY;
                        addr_d  = d_addr & LINE_MASK;
                        wdata_d = d_wdata;
                        write_d = d_write;
                        if ((FIXED_PRIO != 0) && i_req && !starve_hit) begin
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        arb_busy   = busy;
        pmem_read  = busy && !write_q;
        pmem_write = busy && write_q;
        pmem_addr  = busy ? addr_q : '0;
        pmem_wdata = busy ? wdata_q : '0;
        i_resp     = (state_q == I_BUSY) && pmem_resp;
        d_resp     = (state_q == D_BUSY) && pmem_resp;
        i_rdata    = i_resp ? pmem_rdata : '0;
        d_rdata    = d_resp ? pmem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(d_read && d_write))
            else $warning("cacheline_arbiter: d_read and d_write asserted together");
        end
    end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: directed scenarios plus randomized traffic against a grant-order model.
module tb_cacheline_arbiter;

    localparam int LW    = 256;
    localparam int AW    = 32;
    localparam int LIMIT = 4;
    localparam logic [AW-1:0] ALIGN = 32'hFFFF_FFE0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, i_read, d_read, d_write, pmem_resp;
    logic [AW-1:0] i_addr, d_addr;
    logic [LW-1:0] d_wdata, pmem_rdata;

    logic [LW-1:0] r_i_rdata, r_d_rdata, r_pmem_wdata, f_i_rdata, f_d_rdata, f_pmem_wdata;
    logic [AW-1:0] r_pmem_addr, f_pmem_addr;
    logic r_i_resp, r_d_resp, r_pmem_read, r_pmem_write, r_arb_busy;
    logic f_i_resp, f_d_resp, f_pmem_read, f_pmem_write, f_arb_busy;

    bit            sel_fp;
    logic [LW-1:0] s_i_rdata, s_d_rdata, s_pmem_wdata;
    logic [AW-1:0] s_pmem_addr;
    logic          s_i_resp, s_d_resp, s_pmem_read, s_pmem_write, s_arb_busy;

    int checks = 0;
    int passed = 0;

    cacheline_arbiter #(.LINE_W(LW), .ADDR_W(AW), .FIXED_PRIO(0), .STARVE_LIMIT(LIMIT)) dut_rr (
        .clk(clk), .rst(rst), .i_read(i_read), .i_addr(i_addr), .i_rdata(r_i_rdata), .i_resp(r_i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(r_d_rdata), .d_resp(r_d_resp), .pmem_read(r_pmem_read), .pmem_write(r_pmem_write),
        .pmem_addr(r_pmem_addr), .pmem_wdata(r_pmem_wdata), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp), .arb_busy(r_arb_busy)
    );

    cacheline_arbiter #(.LINE_W(LW), .ADDR_W(AW), .FIXED_PRIO(1), .STARVE_LIMIT(LIMIT)) dut_fp (
        .clk(clk), .rst(rst), .i_read(i_read), .i_addr(i_addr), .i_rdata(f_i_rdata), .i_resp(f_i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(f_d_rdata), .d_resp(f_d_resp), .pmem_read(f_pmem_read), .pmem_write(f_pmem_write),
        .pmem_addr(f_pmem_addr), .pmem_wdata(f_pmem_wdata), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp), .arb_busy(f_arb_busy)
    );

    always_comb begin
        s_i_rdata    = sel_fp ? f_i_rdata    : r_i_rdata;
        s_d_rdata    = sel_fp ? f_d_rdata    : r_d_rdata;
        s_pmem_wdata = sel_fp ? f_pmem_wdata : r_pmem_wdata;
        s_pmem_addr  = sel_fp ? f_pmem_addr  : r_pmem_addr;
        s_i_resp     = sel_fp ? f_i_resp     : r_i_resp;
        s_d_resp     = sel_fp ? f_d_resp     : r_d_resp;
        s_pmem_read  = sel_fp ? f_pmem_read  : r_pmem_read;
        s_pmem_write = sel_fp ? f_pmem_write : r_pmem_write;
        s_arb_busy   = sel_fp ? f_arb_busy   : r_arb_busy;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_read = 1'b1; i_addr = 32'h0000_0040;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({r_pmem_read, r_pmem_write, r_i_resp, r_d_resp, r_arb_busy, |r_pmem_addr, |r_pmem_wdata,
                 |r_i_rdata, |r_d_rdata} !== 9'b0)
                $display("FAIL reset_rr_outputs cycle %0d: got nonzero outputs, expected all 0", c);
            else passed++;
            checks++;
            if ({f_pmem_read, f_pmem_write, f_i_resp, f_d_resp, f_arb_busy, |f_pmem_addr, |f_pmem_wdata,
                 |f_i_rdata, |f_d_rdata} !== 9'b0)
                $display("FAIL reset_fp_outputs cycle %0d: got nonzero outputs, expected all 0", c);
            else passed++;
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({r_pmem_read, f_pmem_read} !== 2'b00)
            $display("FAIL reset_release_early: got %b expected 00", {r_pmem_read, f_pmem_read});
        else passed++;
        step();
        checks++;
        if ({r_pmem_read, f_pmem_read, r_pmem_addr} !== {2'b11, 32'h0000_0040})
            $display("FAIL reset_first_cmd: got %b/%h expected 11/00000040", {r_pmem_read, f_pmem_read}, r_pmem_addr);
        else passed++;
        pmem_rdata = {8{32'h1357_9BDF}}; pmem_resp = 1'b1;
        #1;
        checks++;
        if ({r_i_resp, f_i_resp} !== 2'b11)
            $display("FAIL reset_first_resp: got %b expected 11", {r_i_resp, f_i_resp});
        else passed++;
        step();
        pmem_resp = 1'b0; i_read = 1'b0;
    endtask

    task automatic test_lone_i();
        sel_fp = 1'b0;
        i_addr = 32'h0000_1234; i_read = 1'b1;
        #1;
        checks++;
        if (s_pmem_read !== 1'b0) $display("FAIL lone_latency: got pmem_read=%b expected 0", s_pmem_read);
        else passed++;
        step();
        checks++;
        if ({s_pmem_read, s_pmem_write, s_arb_busy, s_pmem_addr} !== {3'b101, 32'h0000_1220})
            $display("FAIL lone_cmd: got rd=%b wr=%b busy=%b addr=%h expected 1 0 1 00001220",
                     s_pmem_read, s_pmem_write, s_arb_busy, s_pmem_addr);
        else passed++;
        step();
        pmem_rdata = {32{8'hA5}}; pmem_resp = 1'b1;
        #1;
        checks++;
        if ({s_i_resp, s_d_resp, s_i_rdata, s_d_rdata} !== {2'b10, {32{8'hA5}}, {LW{1'b0}}})
            $display("FAIL lone_resp: got i_resp=%b d_resp=%b i_rdata=%h d_rdata=%h", s_i_resp, s_d_resp,
                     s_i_rdata, s_d_rdata);
        else passed++;
        step();
        pmem_resp = 1'b0; i_read = 1'b0;
        #1;
        checks++;
        if ({s_pmem_read, s_arb_busy} !== 2'b00)
            $display("FAIL lone_release: got rd=%b busy=%b expected 0 0", s_pmem_read, s_arb_busy);
        else passed++;
    endtask

    // Both sides held high continuously; exp_pattern bit g = 1 means D expected on grant g.
    task automatic run_held_contention(input string name, input int n, input logic [15:0] exp_pattern);
        for (int g = 0; g < n; g++) begin
            logic exp_d;
            exp_d = exp_pattern[g];
            #1;
            checks++;
            if (s_arb_busy !== 1'b0) $display("FAIL %s_gap%0d: got busy=%b expected 0", name, g, s_arb_busy);
            else passed++;
            step();
            checks++;
            if ({s_pmem_write, s_pmem_read, s_pmem_addr} !==
                {exp_d & d_write, ~(exp_d & d_write), (exp_d ? d_addr : i_addr) & ALIGN})
                $display("FAIL %s_grant%0d: got wr=%b rd=%b addr=%h expected owner %s", name, g,
                         s_pmem_write, s_pmem_read, s_pmem_addr, exp_d ? "D" : "I");
            else passed++;
            if (exp_d && d_write) begin
                checks++;
                if (s_pmem_wdata !== d_wdata)
                    $display("FAIL %s_wdata%0d: got %h expected %h", name, g, s_pmem_wdata, d_wdata);
                else passed++;
            end
            pmem_rdata = {8{$urandom}}; pmem_resp = 1'b1;
            #1;
            checks++;
            if ({s_d_resp, s_i_resp} !== {exp_d, ~exp_d})
                $display("FAIL %s_resp%0d: got d_resp=%b i_resp=%b expected owner %s", name, g,
                         s_d_resp, s_i_resp, exp_d ? "D" : "I");
            else passed++;
            step();
            pmem_resp = 1'b0;
        end
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic test_contention_rr();
        sel_fp = 1'b0;
        do_reset();
        i_read = 1'b1; i_addr = 32'hABCD_0E7F;
        d_write = 1'b1; d_addr = 32'h1234_5678; d_wdata = {8{32'hCAFE_F00D}};
        run_held_contention("rr_contend", 4, 16'b0000_0000_0000_0101);
    endtask

    task automatic test_starvation();
        sel_fp = 1'b1;
        do_reset();
        i_read = 1'b1; i_addr = 32'h0000_8888;
        d_read = 1'b1; d_addr = 32'h0000_4444;
        // D D D D I, twice: the second run shows the counter restarted from 0.
        run_held_contention("starve", 10, 16'b0000_0001_1110_1111);
    endtask

    task automatic test_midop_reset();
        sel_fp = 1'b0;
        do_reset();
        d_write = 1'b1; d_addr = 32'h0000_0100; d_wdata = {8{32'h0BAD_BEEF}};
        step();
        checks++;
        if (s_pmem_write !== 1'b1) $display("FAIL midrst_start: got pmem_write=%b expected 1", s_pmem_write);
        else passed++;
        step();
        rst = 1'b1; d_write = 1'b0;
        step();
        checks++;
        if ({s_pmem_write, s_pmem_read, s_arb_busy} !== 3'b000)
            $display("FAIL midrst_abort: got wr=%b rd=%b busy=%b expected 000", s_pmem_write, s_pmem_read, s_arb_busy);
        else passed++;
        rst = 1'b0;
        step();
        step();
        pmem_rdata = {8{32'h7777_7777}}; pmem_resp = 1'b1;
        #1;
        checks++;
        if ({s_d_resp, s_i_resp, |s_d_rdata} !== 3'b000)
            $display("FAIL midrst_late_resp: got d_resp=%b i_resp=%b d_rdata=%h expected no response",
                     s_d_resp, s_i_resp, s_d_rdata);
        else passed++;
        step();
        pmem_resp = 1'b0;
        checks++;
        if (s_arb_busy !== 1'b0) $display("FAIL midrst_idle: got busy=%b expected 0", s_arb_busy);
        else passed++;
    endtask

    task automatic test_illegal();
        sel_fp = 1'b0;
        d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_0FFF; d_wdata = {8{32'h5A5A_1234}};
        step();
        checks++;
        if ({s_pmem_write, s_pmem_read, s_pmem_addr, s_pmem_wdata} !== {2'b10, 32'h0000_0FE0, {8{32'h5A5A_1234}}})
            $display("FAIL illegal_op: got wr=%b rd=%b addr=%h expected write to 00000fe0",
                     s_pmem_write, s_pmem_read, s_pmem_addr);
        else passed++;
        d_read = 1'b0; d_write = 1'b0;
        pmem_rdata = '0; pmem_resp = 1'b1;
        #1;
        checks++;
        if (s_d_resp !== 1'b1) $display("FAIL illegal_resp: got d_resp=%b expected 1", s_d_resp);
        else passed++;
        step();
        pmem_resp = 1'b0;
    endtask

    // Random traffic; the model is just the grant rule plus a loss counter.
    task automatic test_random(input bit fp);
        bit ip, dp, dw, win_d, exp_wr;
        int m_last_d, m_loss, lat;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_wdata, rd;
        sel_fp = fp;
        do_reset();
        ip = 0; dp = 0; dw = 0; m_last_d = 0; m_loss = 0;
        for (int t = 0; t < 60; t++) begin
            if (!ip && $urandom_range(0, 1) == 1) begin
                ip = 1; i_addr = $urandom; i_read = 1'b1;
            end
            if (!dp && $urandom_range(0, 1) == 1) begin
                dp = 1; dw = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = {8{$urandom}};
                d_write = dw; d_read = !dw;
            end
            #1;
            checks++;
            if ({s_arb_busy, s_pmem_read, s_pmem_write} !== 3'b000)
                $display("FAIL rnd%0d_idle t=%0d: got busy=%b rd=%b wr=%b expected 000", fp, t,
                         s_arb_busy, s_pmem_read, s_pmem_write);
            else passed++;
            if (!ip && !dp) begin
                step();
                continue;
            end
            if (ip && dp) win_d = fp ? (m_loss < LIMIT) : (m_last_d == 0);
            else win_d = dp;
            if (fp) begin
                if (!win_d) m_loss = 0;
                else if (ip) m_loss = (m_loss < LIMIT) ? m_loss + 1 : LIMIT;
            end
            m_last_d = win_d ? 1 : 0;
            exp_addr = (win_d ? d_addr : i_addr) & ALIGN;
            exp_wr = win_d && dw;
            exp_wdata = d_wdata;
            step();
            lat = $urandom_range(0, 3);
            for (int k = 0; k <= lat; k++) begin
                checks++;
                if ({s_pmem_read, s_pmem_write, s_pmem_addr} !== {!exp_wr, exp_wr, exp_addr} ||
                    (exp_wr && s_pmem_wdata !== exp_wdata))
                    $display("FAIL rnd%0d_cmd t=%0d k=%0d: got rd=%b wr=%b addr=%h expected rd=%b wr=%b addr=%h",
                             fp, t, k, s_pmem_read, s_pmem_write, s_pmem_addr, !exp_wr, exp_wr, exp_addr);
                else passed++;
                if (k == lat) break;
                if ($urandom_range(0, 2) == 0) begin
                    if (win_d) begin d_read = 1'b0; d_write = 1'b0; d_addr = $urandom; d_wdata = {8{$urandom}}; end
                    else begin i_read = 1'b0; i_addr = $urandom; end
                end
                if (win_d && !ip && $urandom_range(0, 1) == 1) begin ip = 1; i_addr = $urandom; i_read = 1'b1; end
                if (!win_d && !dp && $urandom_range(0, 1) == 1) begin
                    dp = 1; dw = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = {8{$urandom}};
                    d_write = dw; d_read = !dw;
                end
                step();
            end
            rd = {8{$urandom}};
            pmem_rdata = rd; pmem_resp = 1'b1;
            #1;
            checks++;
            if ({s_d_resp, s_i_resp} !== {win_d, !win_d} ||
                (win_d ? s_d_rdata : s_i_rdata) !== rd || (win_d ? s_i_rdata : s_d_rdata) !== {LW{1'b0}})
                $display("FAIL rnd%0d_resp t=%0d: got d_resp=%b i_resp=%b expected owner %s", fp, t,
                         s_d_resp, s_i_resp, win_d ? "D" : "I");
            else passed++;
            step();
            pmem_resp = 1'b0;
            if (win_d) begin dp = 0; d_read = 1'b0; d_write = 1'b0; end
            else begin ip = 0; i_read = 1'b0; end
        end
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        step();
    endtask

    initial begin
        sel_fp = 1'b0;
        rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;
        test_reset();
        test_lone_i();
        test_contention_rr();
        test_starvation();
        test_midop_reset();
        test_illegal();
        test_random(1'b0);
        test_random(1'b1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
